// File: rtl/controlador_registrador.sv
// rtl/controlador_registrador.sv - arbitrated serial TX/RX controller driving an external 4-bit shift register
// Round-robin between transmit and receive requesters; register is hold/load/shift via reg_sel.
module controlador_registrador (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_req,
  input  logic [3:0] tx_data,
  output logic       tx_ack,
  input  logic       rx_req,
  output logic       rx_ack,
  output logic [3:0] rx_data,
  input  logic       serial_in,
  output logic       serial_out,
  output logic       serial_en,
  output logic       reg_sel,
  output logic [3:0] reg_din,
  output logic       reg_din_serie,
  input  logic [3:0] reg_dout,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, TX_LOAD, TX_SHIFT, RX_SHIFT, DONE} state_t;

  localparam logic GRANT_TX = 1'b0;
  localparam logic GRANT_RX = 1'b1;

  state_t     state, state_nx;
  logic [1:0] bit_cnt, bit_cnt_nx;
  logic       last_grant, last_grant_nx;
  logic [3:0] word, word_nx;
  logic       grant_tx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= 2'd0;
      last_grant <= GRANT_RX;
      word       <= 4'd0;
    end else begin
      state      <= state_nx;
      bit_cnt    <= bit_cnt_nx;
      last_grant <= last_grant_nx;
      word       <= word_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    bit_cnt_nx    = bit_cnt;
    last_grant_nx = last_grant;
    word_nx       = word;
    grant_tx      = 1'b0;
    tx_ack        = 1'b0;
    rx_ack        = 1'b0;
    rx_data       = 4'd0;
    serial_out    = 1'b0;
    serial_en     = 1'b0;
    reg_sel       = 1'b0;
    reg_din       = reg_dout;  // register has no enable: feed it back to hold
    reg_din_serie = 1'b0;
    busy          = (state != IDLE);

    case (state)
      IDLE: begin
        // On a tie, the requester not served last wins
        grant_tx = tx_req && (!rx_req || (last_grant == GRANT_RX));
        if (grant_tx) begin
          word_nx       = tx_data;
          last_grant_nx = GRANT_TX;
          state_nx      = TX_LOAD;
        end else if (rx_req) begin
          last_grant_nx = GRANT_RX;
          bit_cnt_nx    = 2'd0;
          state_nx      = RX_SHIFT;
        end
      end
      TX_LOAD: begin
        reg_din    = word;
        bit_cnt_nx = 2'd0;
        state_nx   = TX_SHIFT;
      end
      TX_SHIFT: begin
        reg_sel    = 1'b1;
        serial_en  = 1'b1;
        serial_out = reg_dout[3];
        bit_cnt_nx = bit_cnt + 2'd1;
        if (bit_cnt == 2'd3) state_nx = DONE;
      end
      RX_SHIFT: begin
        reg_sel       = 1'b1;
        reg_din_serie = serial_in;
        bit_cnt_nx    = bit_cnt + 2'd1;
        if (bit_cnt == 2'd3) state_nx = DONE;
      end
      DONE: begin
        if (last_grant == GRANT_TX) begin
          tx_ack = 1'b1;
        end else begin
          rx_ack  = 1'b1;
          rx_data = reg_dout;
        end
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_controlador_registrador.sv
// tb/tb_controlador_registrador.sv - self-checking bench for controlador_registrador
// Vector table plus hand sequences; scoreboard queues for serial bits, acks and rx words.
module tb_controlador_registrador;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_req, rx_req, serial_in;
  logic [3:0] tx_data;
  logic       tx_ack, rx_ack, serial_out, serial_en, reg_sel, reg_din_serie, busy;
  logic [3:0] rx_data, reg_din, reg_dout;

  logic       pre;
  logic [3:0] pre_val;
  logic       mon_en = 1'b0;
  logic       prev_ack = 1'b0;

  int checks = 0;
  int failures = 0;

  logic       exp_bits[$];
  logic       exp_ack[$];
  logic [3:0] exp_rx[$];

  typedef struct {
    logic       is_tx;
    logic [3:0] data;
    int         drop_at;
    int         exp_lat;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  controlador_registrador dut (
    .clk           (clk),
    .reset         (reset),
    .tx_req        (tx_req),
    .tx_data       (tx_data),
    .tx_ack        (tx_ack),
    .rx_req        (rx_req),
    .rx_ack        (rx_ack),
    .rx_data       (rx_data),
    .serial_in     (serial_in),
    .serial_out    (serial_out),
    .serial_en     (serial_en),
    .reg_sel       (reg_sel),
    .reg_din       (reg_din),
    .reg_din_serie (reg_din_serie),
    .reg_dout      (reg_dout),
    .busy          (busy)
  );

  // External shift register the controller drives
  always @(posedge clk) begin
    if (pre)          reg_dout <= pre_val;
    else if (reg_sel) reg_dout <= {reg_dout[2:0], reg_din_serie};
    else              reg_dout <= reg_din;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=unexpected expected=none", name);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("ack_exclusive", {31'd0, tx_ack & rx_ack}, 32'd0);
      check("ack_single_cycle", {31'd0, (tx_ack | rx_ack) & prev_ack}, 32'd0);
      if (!serial_en) check("serial_out_idle", {31'd0, serial_out}, 32'd0);
      if (!rx_ack) check("rx_data_idle", {28'd0, rx_data}, 32'd0);
      if (serial_en) begin
        if (exp_bits.size() == 0) fail_now("serial_unexpected");
        else check("serial_bit", {31'd0, serial_out}, {31'd0, exp_bits.pop_front()});
      end
      if (tx_ack | rx_ack) begin
        if (exp_ack.size() == 0) fail_now("ack_unexpected");
        else check("ack_kind", {31'd0, rx_ack}, {31'd0, exp_ack.pop_front()});
        if (rx_ack) begin
          if (exp_rx.size() == 0) fail_now("rx_unexpected");
          else check("rx_data", {28'd0, rx_data}, {28'd0, exp_rx.pop_front()});
        end
      end
      prev_ack <= tx_ack | rx_ack;
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    int lat = 0;
    @(posedge clk); #1;
    if (v.is_tx) begin
      tx_data = v.data;
      tx_req  = 1'b1;
      for (int i = 3; i >= 0; i--) exp_bits.push_back(v.data[i]);
      exp_ack.push_back(1'b0);
    end else begin
      rx_req = 1'b1;
      exp_ack.push_back(1'b1);
      exp_rx.push_back(v.data);
    end
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (k == 1) tx_data = ~v.data;
      if (!v.is_tx && k <= 4) serial_in = v.data[4-k];
      if (k == v.drop_at) begin
        tx_req = 1'b0;
        rx_req = 1'b0;
      end
      @(negedge clk);
      if (tx_ack | rx_ack) lat = k;
    end
    check($sformatf("vec%0d_latency", idx), lat, v.exp_lat);
    @(posedge clk); #1;
    tx_req = 1'b0; rx_req = 1'b0; tx_data = 4'd0; serial_in = 1'b0;
  endtask

  initial begin
    int n_ack;
    vecs[0] = '{1'b1, 4'b1011, 0, 6};
    vecs[1] = '{1'b0, 4'b0110, 0, 5};
    vecs[2] = '{1'b1, 4'b0000, 0, 6};
    vecs[3] = '{1'b1, 4'b1111, 0, 6};
    vecs[4] = '{1'b0, 4'b1001, 2, 5};
    vecs[5] = '{1'b0, 4'b1111, 0, 5};
    vecs[6] = '{1'b1, 4'b0110, 3, 6};

    reset = 1'b1; tx_req = 1'b0; rx_req = 1'b0; tx_data = 4'd0; serial_in = 1'b0;
    pre = 1'b1; pre_val = 4'd0;
    @(posedge clk); #1;
    pre = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_serial_en", {31'd0, serial_en}, 32'd0);
    check("rst_tx_ack", {31'd0, tx_ack}, 32'd0);
    check("rst_rx_ack", {31'd0, rx_ack}, 32'd0);
    check("rst_reg_sel", {31'd0, reg_sel}, 32'd0);
    check("rst_din_serie", {31'd0, reg_din_serie}, 32'd0);
    check("rst_reg_din", {28'd0, reg_din}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Idle hold with a known register value
    pre = 1'b1; pre_val = 4'b1001;
    @(posedge clk); #1;
    pre = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_reg_sel", {31'd0, reg_sel}, 32'd0);
      check("idle_reg_din", {28'd0, reg_din}, 32'h9);
      check("idle_reg_dout", {28'd0, reg_dout}, 32'h9);
      check("idle_busy", {31'd0, busy}, 32'd0);
    end

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Both requests held from reset: TX, RX, TX
    reset = 1'b1; tx_req = 1'b1; rx_req = 1'b1; tx_data = 4'b1010; serial_in = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 3; i >= 0; i--) exp_bits.push_back(tx_data[i]);
    exp_ack.push_back(1'b0);
    exp_ack.push_back(1'b1);
    exp_rx.push_back(4'b0000);
    for (int i = 3; i >= 0; i--) exp_bits.push_back(tx_data[i]);
    exp_ack.push_back(1'b0);
    n_ack = 0;
    for (int k = 0; k < 40 && n_ack < 3; k++) begin
      @(negedge clk);
      if (tx_ack | rx_ack) n_ack++;
    end
    check("rr_ack_count", n_ack, 3);
    @(posedge clk); #1;
    tx_req = 1'b0; rx_req = 1'b0;
    @(posedge clk); #1;

    // Reset during the second TX_SHIFT cycle abandons the transfer
    tx_data = 4'b1011; tx_req = 1'b1;
    exp_bits.push_back(1'b1);
    exp_bits.push_back(1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1; tx_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_serial_en", {31'd0, serial_en}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("abort_no_ack", {31'd0, tx_ack}, 32'd0);
    end

    check("left_bits", exp_bits.size(), 0);
    check("left_acks", exp_ack.size(), 0);
    check("left_rx", exp_rx.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/controlador_registrador.md
CONTROLADOR_REGISTRADOR -- requirements
Module: controlador_registrador

Interface
REQ-001 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-002 reset  input  1  synchronous, active-high reset; SHALL take effect only on a rising clk edge.
REQ-003 tx_req  input  1  transmit requester asks to serialize tx_data; SHALL be held until tx_ack.
REQ-004 tx_data  input  4  word to transmit; sampled on the grant edge only.
REQ-005 tx_ack  output  1  one-cycle pulse marking transmit completion.
REQ-006 rx_req  input  1  receive requester asks to collect 4 serial bits; SHALL be held until rx_ack.
REQ-007 rx_ack  output  1  one-cycle pulse marking receive completion.
REQ-008 rx_data  output  4  received word; valid only while rx_ack=1, else 4'b0.
REQ-009 serial_in  input  1  serial receive line, MSB first.
REQ-010 serial_out  output  1  serial transmit line, MSB first; 0 when serial_en=0.
REQ-011 serial_en  output  1  high on each cycle serial_out carries a valid bit.
REQ-012 reg_sel  output  1  drives the shared shift register SEL (0 parallel load, 1 shift left, serial bit into LSB).
REQ-013 reg_din  output  4  drives the register parallel input.
REQ-014 reg_din_serie  output  1  drives the register serial input.
REQ-015 reg_dout  input  4  register contents.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, TX_LOAD, TX_SHIFT, RX_SHIFT, DONE, plus a 2-bit bit counter and a 1-bit last_grant flag.
REQ-018 The register has no enable, so in IDLE and DONE the block SHALL drive reg_sel=0, reg_din=reg_dout (hold).
REQ-019 IDLE with only tx_req=1 SHALL grant TX: latch tx_data, go to TX_LOAD; with only rx_req=1 SHALL go to RX_SHIFT.
REQ-020 IDLE with both requests SHALL grant the requester not served last (round-robin); last_grant updates on every grant.
REQ-021 TX_LOAD (1 cycle) SHALL drive reg_sel=0, reg_din=latched word, then go to TX_SHIFT with counter=0.
REQ-022 TX_SHIFT (exactly 4 cycles) SHALL drive reg_sel=1, reg_din_serie=0, serial_en=1, serial_out=reg_dout[3], giving bits 3,2,1,0 in order; after counter=3 go to DONE.
REQ-023 RX_SHIFT (exactly 4 cycles) SHALL drive reg_sel=1, reg_din_serie=serial_in, sampling one bit per edge; after counter=3 go to DONE.
REQ-024 DONE (1 cycle) SHALL pulse the ack of the served requester; for RX, rx_data=reg_dout; then go to IDLE.
REQ-025 Latency: request seen in IDLE cycle N -> TX bits on cycles N+2..N+5, tx_ack at N+6; RX bits sampled at ends of N+1..N+4, rx_ack at N+5.
REQ-026 Requests SHALL be ignored outside IDLE; dropping a request mid-operation SHALL NOT abort it; a request still high in IDLE after DONE is a new request.
REQ-027 tx_ack and rx_ack SHALL never be high together, nor for more than one consecutive cycle.

Reset
REQ-028 On reset: state IDLE, counter 0, last_grant=RX (TX wins first tie), latched word 0, tx_ack=rx_ack=0, rx_data=0, serial_out=0, serial_en=0, busy=0, reg_sel=0, reg_din=reg_dout, reg_din_serie=0.
REQ-029 Reset asserted mid-operation SHALL abandon it with no ack issued; reset SHALL override all other inputs.

Verification
REQ-030 tx_req=1, tx_data=4'b1011 -> serial_en high 4 cycles with serial_out 1,0,1,1; tx_ack one pulse at N+6.
REQ-031 rx_req=1, serial_in 0,1,1,0 -> rx_ack at N+5 with rx_data=4'b0110.
REQ-032 tx_req and rx_req both high from reset, held through acks -> TX served first, then RX; then TX again (alternation).
REQ-033 Reset pulsed on 2nd TX_SHIFT cycle -> busy=0 next cycle, no tx_ack, serial_en=0.
REQ-034 IDLE with reg_dout=4'b1001, no requests for 10 cycles -> reg_sel=0, reg_din=4'b1001 every cycle, register value unchanged.
REQ-035 rx_req dropped during RX_SHIFT -> operation completes, rx_ack still pulses at N+5.
